// File: rtl/cpu_dmem_resp_if.sv
// MEM-stage data port between the pipeline datapath (master) and the data memory (slave).
interface cpu_dmem_resp_if;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallreq_from_mem;
    logic        addr_err;

    modport master (
        output mem_en, mem_we, sel, mem_addr, mem_wdata,
        input  mem_rdata, stallreq_from_mem, addr_err
    );

    modport slave (
        input  mem_en, mem_we, sel, mem_addr, mem_wdata,
        output mem_rdata, stallreq_from_mem, addr_err
    );
endinterface

// File: rtl/cpu_dmem_resp.sv
// Data-memory responder: byte-writable word RAM behind the MEM-stage port, stalling the
// pipeline for a fixed number of wait states per access.
module cpu_dmem_resp #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    cpu_dmem_resp_if.slave  mem
);

    localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
    localparam bit          NoWait = (WAIT_CYCLES == 0);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;

    logic                  r_we;
    logic [3:0]            r_sel;
    logic [31:0]           r_wdata;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_oor;

    logic [31:0]           r_mem [Depth];
    logic [31:0]           r_rdata;
    logic                  r_addr_err;

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_in_oor;
    logic                  w_req_we;
    logic [3:0]            w_req_sel;
    logic [31:0]           w_req_wdata;
    logic [ADDR_WIDTH-1:0] w_req_idx;
    logic                  w_req_oor;
    logic                  w_unused_addr;

    // Bits [31:29] alias kseg0/kseg1; bits [1:0] are covered by sel.
    assign w_unused_addr = ^{mem.mem_addr[31:29], mem.mem_addr[1:0]};
    assign w_in_oor      = |mem.mem_addr[28:ADDR_WIDTH+2];
    assign w_accept      = (r_state == StIdle) && mem.mem_en;

    // With no wait states the commit happens straight out of IDLE, so use the live inputs.
    assign w_req_we    = (r_state == StIdle) ? mem.mem_we                       : r_we;
    assign w_req_sel   = (r_state == StIdle) ? mem.sel                          : r_sel;
    assign w_req_wdata = (r_state == StIdle) ? mem.mem_wdata                    : r_wdata;
    assign w_req_idx   = (r_state == StIdle) ? mem.mem_addr[ADDR_WIDTH+1:2]     : r_idx;
    assign w_req_oor   = (r_state == StIdle) ? w_in_oor                         : r_oor;

    // Gated by rst so an access interrupted by reset never reaches the RAM.
    assign w_commit = rst && ((w_accept && NoWait) || ((r_state == StWait) && (r_cnt == 4'd1)));

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            StIdle: begin
                if (mem.mem_en) begin
                    w_cnt_next   = 4'(WAIT_CYCLES);
                    w_state_next = NoWait ? StResp : StWait;
                end
            end
            StWait: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_next = StResp;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State, counter and latched request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_sel   <= 4'd0;
            r_wdata <= 32'd0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= mem.mem_we;
                r_sel   <= mem.sel;
                r_wdata <= mem.mem_wdata;
                r_idx   <= mem.mem_addr[ADDR_WIDTH+1:2];
                r_oor   <= w_in_oor;
            end
        end
    end

    // Byte-lane RAM write on the commit edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_req_we && !w_req_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (w_req_sel[i]) begin
                    r_mem[w_req_idx][8*i +: 8] <= w_req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data is only refreshed by a completing read; addr_err pulses for the RESP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata    <= 32'd0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_commit && w_req_oor;
            if (w_commit && !w_req_we) begin
                r_rdata <= w_req_oor ? 32'd0 : r_mem[w_req_idx];
            end
        end
    end

    assign mem.mem_rdata         = r_rdata;
    assign mem.addr_err          = r_addr_err;
    assign mem.stallreq_from_mem = rst && (w_accept || (r_state == StWait));

endmodule

// File: tb/tb_cpu_dmem_resp.sv
// Directed bench for cpu_dmem_resp: one instance with two wait states, one with none.
module tb_cpu_dmem_resp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_dmem_resp_if bus ();
    cpu_dmem_resp_if bus0 ();

    cpu_dmem_resp #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .mem (bus.slave)
    );

    cpu_dmem_resp #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .mem (bus0.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rd  = 32'd0;
    logic [31:0] last_rd0 = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit z, input bit en, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel);
        if (z) begin
            bus0.mem_en = en; bus0.mem_we = we; bus0.mem_addr = addr;
            bus0.mem_wdata = wdata; bus0.sel = sel;
        end else begin
            bus.mem_en = en; bus.mem_we = we; bus.mem_addr = addr;
            bus.mem_wdata = wdata; bus.sel = sel;
        end
    endtask

    function automatic logic [31:0] get_rd(input bit z);
        return z ? bus0.mem_rdata : bus.mem_rdata;
    endfunction

    function automatic logic get_stall(input bit z);
        return z ? bus0.stallreq_from_mem : bus.stallreq_from_mem;
    endfunction

    function automatic logic get_err(input bit z);
        return z ? bus0.addr_err : bus.addr_err;
    endfunction

    // Called just after a rising edge in an IDLE cycle; returns just after the edge out of RESP.
    task automatic access(input bit z, input string tag, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          input logic [31:0] exp_rd, input bit exp_err, input bit hold);
        int w;
        logic [31:0] prev;
        w    = z ? 0 : 2;
        prev = z ? last_rd0 : last_rd;
        drive(z, 1'b1, we, addr, wdata, sel);
        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            chk({tag, "_stall"}, 32'(get_stall(z)), 32'd1);
            chk({tag, "_err_lo"}, 32'(get_err(z)), 32'd0);
            if (k > 0) chk({tag, "_rd_hold"}, get_rd(z), prev);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, "_resp_stall"}, 32'(get_stall(z)), 32'd0);
        chk({tag, "_err"}, 32'(get_err(z)), 32'(exp_err));
        if (!we) begin
            chk({tag, "_rdata"}, get_rd(z), exp_rd);
            if (z) last_rd0 = exp_rd; else last_rd = exp_rd;
        end else begin
            chk({tag, "_wr_rd_hold"}, get_rd(z), prev);
        end
        @(posedge clk); #1;
        if (!hold) drive(z, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(bus.stallreq_from_mem), 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_err", 32'(bus.addr_err), 32'd0);
        chk("rst_stall0", 32'(bus0.stallreq_from_mem), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        // Harmless sel=0000 write; its first cycle shows stall rising right after reset release.
        access(1'b0, "rst_rel", 1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0, 1'b0);

        // Word write then aliased read.
        access(1'b0, "wr_word", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 32'd0, 1'b0, 1'b0);
        access(1'b0, "rd_alias", 1'b0, 32'hA000_0010, 32'd0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Byte lanes.
        access(1'b0, "pre_lane", 1'b1, 32'h20, 32'h1122_3344, 4'b1111, 32'd0, 1'b0, 1'b0);
        access(1'b0, "wr_lane2", 1'b1, 32'h20, 32'h00AA_0000, 4'b0100, 32'd0, 1'b0, 1'b0);
        access(1'b0, "rd_lane2", 1'b0, 32'h20, 32'd0, 4'b0000, 32'h11AA_3344, 1'b0, 1'b0);
        access(1'b0, "wr_sel0", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0, 1'b0);
        access(1'b0, "rd_sel0", 1'b0, 32'h20, 32'd0, 4'b1111, 32'h11AA_3344, 1'b0, 1'b0);

        // Back-to-back reads with mem_en held.
        access(1'b0, "pre_b0", 1'b1, 32'h30, 32'h0101_0101, 4'b1111, 32'd0, 1'b0, 1'b0);
        access(1'b0, "pre_b1", 1'b1, 32'h34, 32'h0202_0202, 4'b1111, 32'd0, 1'b0, 1'b0);
        access(1'b0, "pre_b2", 1'b1, 32'h38, 32'h0303_0303, 4'b1111, 32'd0, 1'b0, 1'b0);
        access(1'b0, "b2b_0", 1'b0, 32'h30, 32'd0, 4'b1111, 32'h0101_0101, 1'b0, 1'b1);
        access(1'b0, "b2b_1", 1'b0, 32'h34, 32'd0, 4'b1111, 32'h0202_0202, 1'b0, 1'b1);
        access(1'b0, "b2b_2", 1'b0, 32'h38, 32'd0, 4'b1111, 32'h0303_0303, 1'b0, 1'b0);

        // Out of range.
        access(1'b0, "pre_w0", 1'b1, 32'h0, 32'h0BAD_F00D, 4'b1111, 32'd0, 1'b0, 1'b0);
        access(1'b0, "rd_oor", 1'b0, 32'h0001_0000, 32'd0, 4'b1111, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("oor_err_pulse", 32'(bus.addr_err), 32'd0);
        @(posedge clk); #1;
        access(1'b0, "wr_oor", 1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 4'b1111, 32'd0, 1'b1, 1'b0);
        access(1'b0, "rd_w0", 1'b0, 32'h0, 32'd0, 4'b1111, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Reset in the second WAIT cycle of a write to word 5.
        access(1'b0, "pre_w5", 1'b1, 32'h14, 32'hCAFE_F00D, 4'b1111, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 32'h14, 32'h1234_5678, 4'b1111);
        @(negedge clk);
        chk("mid_stall_t0", 32'(bus.stallreq_from_mem), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_stall_wait2", 32'(bus.stallreq_from_mem), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_stall_drop", 32'(bus.stallreq_from_mem), 32'd0);
        chk("mid_rdata_rst", bus.mem_rdata, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        last_rd  = 32'd0;
        last_rd0 = 32'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        access(1'b0, "rd_w5", 1'b0, 32'h14, 32'd0, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0);

        // Zero wait states: one stall cycle per access.
        access(1'b1, "z_wr", 1'b1, 32'h0C, 32'hA5A5_5A5A, 4'b1111, 32'd0, 1'b0, 1'b0);
        access(1'b1, "z_rd", 1'b0, 32'h0C, 32'd0, 4'b1111, 32'hA5A5_5A5A, 1'b0, 1'b0);
        access(1'b1, "z_rd_oor", 1'b0, 32'h0002_000C, 32'd0, 4'b1111, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("z_idle_stall", 32'(bus0.stallreq_from_mem), 32'd0);
        chk("z_idle_err", 32'(bus0.addr_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
